// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle between the pipeline datapath (master) and hazard_ctrl (slave).
// Carries the register tags, memory handshake and all stall/forward controls.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic [REG_W-1:0] idex_rs;
  logic [REG_W-1:0] idex_rt;
  logic             idex_memread;
  logic [REG_W-1:0] exmem_rd;
  logic             exmem_regwrite;
  logic [REG_W-1:0] memwb_rd;
  logic             memwb_regwrite;
  logic             id_branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             pipe_freeze;
  logic             mem_error;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output ifid_rs, ifid_rt, idex_rs, idex_rt, idex_memread,
           exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite,
           id_branch_taken, mem_req, mem_ready,
    input  forward_a, forward_b, pc_write, ifid_write, idex_bubble,
           ifid_flush, pipe_freeze, mem_error, stall_count
  );

  modport slave (
    input  ifid_rs, ifid_rt, idex_rs, idex_rt, idex_memread,
           exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite,
           id_branch_taken, mem_req, mem_ready,
    output forward_a, forward_b, pc_write, ifid_write, idex_bubble,
           ifid_flush, pipe_freeze, mem_error, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding selects, load-use bubble,
// branch flush, data-memory freeze with watchdog, and a saturating stall counter.
//
// state    | meaning
// RUN      | normal flow; memory request either acknowledged or not yet issued
// MEM_WAIT | pipeline frozen waiting for mem_ready; watchdog counting
// HALT     | watchdog expired; pipeline frozen until reset, mem_error set
module hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input logic        clk,
  input logic        rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int WC_W = $clog2(TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_error_q, mem_error_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             mem_stall;
  logic             load_use;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             pipe_freeze;

  // EX/MEM result is newer than MEM/WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] exmem_rd,
    input logic             exmem_we,
    input logic [REG_W-1:0] memwb_rd,
    input logic             memwb_we
  );
    if (exmem_we && (exmem_rd != '0) && (exmem_rd == src))
      return 2'b10;
    else if (memwb_we && (memwb_rd != '0) && (memwb_rd == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    hz.forward_a = fwd_sel(hz.idex_rs, hz.exmem_rd, hz.exmem_regwrite,
                           hz.memwb_rd, hz.memwb_regwrite);
    hz.forward_b = fwd_sel(hz.idex_rt, hz.exmem_rd, hz.exmem_regwrite,
                           hz.memwb_rd, hz.memwb_regwrite);
  end

  always_comb begin
    mem_stall = ((state_q == RUN) && hz.mem_req && !hz.mem_ready) ||
                ((state_q == MEM_WAIT) && !hz.mem_ready) ||
                (state_q == HALT);
    load_use  = hz.idex_memread && (hz.idex_rt != '0) &&
                ((hz.idex_rt == hz.ifid_rs) || (hz.idex_rt == hz.ifid_rt));
  end

  // A branch seen during a stall stays in ID and gets flushed once the stall clears.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    pipe_freeze = 1'b0;
    if (mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (hz.id_branch_taken) begin
      ifid_flush  = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;
    case (state_q)
      RUN: begin
        if (hz.mem_req && !hz.mem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          state_d = RUN;
        end else if (wait_cnt_q == WC_LAST) begin
          state_d     = HALT;
          mem_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    hz.pc_write    = pc_write;
    hz.ifid_write  = ifid_write;
    hz.idex_bubble = idex_bubble;
    hz.ifid_flush  = ifid_flush;
    hz.pipe_freeze = pipe_freeze;
    hz.mem_error   = mem_error_q;
    hz.stall_count = stall_cnt_q;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT=4 and a 4-bit stall counter so
// the watchdog and saturation cases are reachable quickly.
module tb_hazard_ctrl;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  hazard_ctrl_if #(.REG_W(5), .CNT_W(4)) hz ();

  hazard_ctrl #(.REG_W(5), .CNT_W(4), .TIMEOUT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    hz.ifid_rs = '0; hz.ifid_rt = '0; hz.idex_rs = '0; hz.idex_rt = '0;
    hz.idex_memread = 1'b0; hz.exmem_rd = '0; hz.exmem_regwrite = 1'b0;
    hz.memwb_rd = '0; hz.memwb_regwrite = 1'b0; hz.id_branch_taken = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
    #1;
    chk("rst_state", 16'(dut.state_q), 16'd0);
    chk("rst_stall_count", 16'(hz.stall_count), 16'd0);
    chk("rst_mem_error", 16'(hz.mem_error), 16'd0);
    chk("rst_pc_write", 16'(hz.pc_write), 16'd1);
    chk("rst_ifid_write", 16'(hz.ifid_write), 16'd1);
    chk("rst_freeze", 16'(hz.pipe_freeze), 16'd0);
    chk("rst_fwd_a", 16'(hz.forward_a), 16'd0);
    #12;
    rst_n = 1'b1;

    // forwarding
    hz.exmem_rd = 5'd8; hz.idex_rs = 5'd8; hz.memwb_rd = 5'd8;
    hz.exmem_regwrite = 1'b1; hz.memwb_regwrite = 1'b1;
    #1;
    chk("fwd_a_exmem", 16'(hz.forward_a), 16'h2);
    hz.exmem_regwrite = 1'b0;
    #1;
    chk("fwd_a_memwb", 16'(hz.forward_a), 16'h1);
    hz.exmem_rd = 5'd0; hz.memwb_rd = 5'd0; hz.idex_rs = 5'd0;
    hz.exmem_regwrite = 1'b1;
    #1;
    chk("fwd_a_r0", 16'(hz.forward_a), 16'h0);
    hz.idex_rt = 5'd3; hz.memwb_rd = 5'd3; hz.exmem_rd = 5'd4;
    #1;
    chk("fwd_b_memwb", 16'(hz.forward_b), 16'h1);
    chk("fwd_a_nomatch", 16'(hz.forward_a), 16'h0);
    hz.exmem_rd = 5'd3;
    #1;
    chk("fwd_b_exmem", 16'(hz.forward_b), 16'h2);
    hz.exmem_regwrite = 1'b0; hz.memwb_regwrite = 1'b0;
    hz.exmem_rd = '0; hz.memwb_rd = '0; hz.idex_rt = '0;

    // load into r0 never stalls
    hz.idex_memread = 1'b1; hz.idex_rt = 5'd0; hz.ifid_rt = 5'd0;
    #1;
    chk("lu_r0_pc_write", 16'(hz.pc_write), 16'd1);

    // load-use with a taken branch in ID
    hz.idex_rt = 5'd9; hz.ifid_rt = 5'd9; hz.id_branch_taken = 1'b1;
    #1;
    chk("lu_pc_write", 16'(hz.pc_write), 16'd0);
    chk("lu_ifid_write", 16'(hz.ifid_write), 16'd0);
    chk("lu_bubble", 16'(hz.idex_bubble), 16'd1);
    chk("lu_flush", 16'(hz.ifid_flush), 16'd0);
    chk("lu_freeze", 16'(hz.pipe_freeze), 16'd0);
    cyc(1);
    chk("lu_stall_count", 16'(hz.stall_count), 16'd1);
    hz.idex_memread = 1'b0;
    #1;
    chk("br_flush", 16'(hz.ifid_flush), 16'd1);
    chk("br_pc_write", 16'(hz.pc_write), 16'd1);
    chk("br_bubble", 16'(hz.idex_bubble), 16'd0);
    hz.id_branch_taken = 1'b0;
    #1;
    chk("norm_flush", 16'(hz.ifid_flush), 16'd0);
    chk("norm_ifid_write", 16'(hz.ifid_write), 16'd1);
    cyc(1);
    chk("norm_stall_count", 16'(hz.stall_count), 16'd1);

    // memory wait acknowledged after 3 MEM_WAIT cycles
    rst_pulse();
    hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
    #1;
    chk("mw_run_freeze", 16'(hz.pipe_freeze), 16'd1);
    chk("mw_run_state", 16'(dut.state_q), 16'd0);
    cyc(1);
    chk("mw_state1", 16'(dut.state_q), 16'd1);
    chk("mw_freeze1", 16'(hz.pipe_freeze), 16'd1);
    cyc(3);
    chk("mw_state3", 16'(dut.state_q), 16'd1);
    chk("mw_stall_count", 16'(hz.stall_count), 16'd4);
    hz.mem_ready = 1'b1;
    #1;
    chk("mw_ack_freeze", 16'(hz.pipe_freeze), 16'd0);
    chk("mw_ack_pc_write", 16'(hz.pc_write), 16'd1);
    cyc(1);
    chk("mw_back_run", 16'(dut.state_q), 16'd0);
    chk("mw_stall_hold", 16'(hz.stall_count), 16'd4);
    chk("mw_fast_freeze", 16'(hz.pipe_freeze), 16'd0);
    cyc(1);
    chk("mw_fast_state", 16'(dut.state_q), 16'd0);
    hz.mem_req = 1'b0;

    // async reset in the middle of MEM_WAIT
    hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
    cyc(2);
    chk("arst_pre_state", 16'(dut.state_q), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_state", 16'(dut.state_q), 16'd0);
    chk("arst_stall_count", 16'(hz.stall_count), 16'd0);
    rst_n = 1'b1;
    #1;

    // watchdog: 1 RUN + 4 MEM_WAIT frozen cycles, then HALT
    rst_pulse();
    cyc(4);
    chk("wd_state_e4", 16'(dut.state_q), 16'd1);
    chk("wd_err_e4", 16'(hz.mem_error), 16'd0);
    cyc(1);
    chk("wd_state_halt", 16'(dut.state_q), 16'd2);
    chk("wd_err", 16'(hz.mem_error), 16'd1);
    chk("wd_stall_count", 16'(hz.stall_count), 16'd5);
    hz.mem_ready = 1'b1;
    #1;
    chk("wd_halt_freeze", 16'(hz.pipe_freeze), 16'd1);
    cyc(10);
    chk("wd_err_sticky", 16'(hz.mem_error), 16'd1);
    chk("sat_reach", 16'(hz.stall_count), 16'hf);
    cyc(3);
    chk("sat_hold", 16'(hz.stall_count), 16'hf);
    chk("wd_still_halt", 16'(dut.state_q), 16'd2);
    rst_n = 1'b0;
    #1;
    chk("wd_rst_state", 16'(dut.state_q), 16'd0);
    chk("wd_rst_err", 16'(hz.mem_error), 16'd0);
    chk("wd_rst_stall", 16'(hz.stall_count), 16'd0);
    chk("wd_rst_freeze", 16'(hz.pipe_freeze), 16'd0);
    rst_n = 1'b1;
    hz.mem_req = 1'b0;
    cyc(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule
